// File: rtl/pwm_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module      : pwm_ctrl_pkg
// Description : Shared types and constants for the PWM duty ramp scheduler.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package pwm_ctrl_pkg;

    localparam int DUTY_W        = 8;
    localparam int DUTY_MAX      = 250;
    localparam int PERIOD_CYCLES = 2500;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RAMP_UP = 2'd1,
        ST_RAMP_DN = 2'd2,
        ST_ESTOP   = 2'd3
    } sched_state_t;

    // Clamp a requested code to the largest legal duty.
    function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W-1:0] duty,
                                                   input logic [DUTY_W-1:0] limit);
        return (duty > limit) ? limit : duty;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_ramp_scheduler_if.sv
//------------------------------------------------------------------------------
// Module      : pwm_ramp_scheduler_if
// Description : Target-duty valid/ready command channel.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pwm_ramp_scheduler_if;
    import pwm_ctrl_pkg::*;

    logic [DUTY_W-1:0] target_duty;
    logic              target_valid;
    logic              target_ready;

    modport master (
        output target_duty,
        output target_valid,
        input  target_ready
    );

    modport slave (
        input  target_duty,
        input  target_valid,
        output target_ready
    );
endinterface

`default_nettype wire

// File: rtl/pwm_ramp_scheduler_period_timer.sv
//------------------------------------------------------------------------------
// Module      : pwm_period_timer
// Description : Free-running 0..PERIOD_CYCLES-1 wrap counter with end-of-period pulse.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pwm_period_timer #(
    parameter int PERIOD_CYCLES = 2500
) (
    input  wire logic clock,
    input  wire logic reset,
    output logic      period_tick
);
    localparam int CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PERIOD_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last      = (r_count == C_LAST);
    assign period_tick = w_last;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end
endmodule

`default_nettype wire

// File: rtl/pwm_ramp_scheduler.sv
//------------------------------------------------------------------------------
// Module      : pwm_ramp_scheduler
// Description : Slews the PWM duty toward a commanded target once per period.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pwm_ramp_scheduler
    import pwm_ctrl_pkg::*;
#(
    parameter int PERIOD_CYCLES = pwm_ctrl_pkg::PERIOD_CYCLES,
    parameter int DUTY_MAX      = pwm_ctrl_pkg::DUTY_MAX,
    parameter int STEP          = 5
) (
    input  wire logic           clock,
    input  wire logic           reset,
    pwm_ramp_scheduler_if.slave tgt,
    input  wire logic           estop,
    output logic [DUTY_W-1:0]   duty_out,
    output logic                period_tick,
    output logic                busy,
    output logic                at_target,
    output logic                err_range
);
    localparam logic [DUTY_W-1:0] C_DUTY_MAX = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W:0]   C_STEP_W   = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W-1:0] C_STEP     = DUTY_W'(STEP);

    sched_state_t      r_state, w_state_next;
    logic [DUTY_W-1:0] r_duty, w_duty_next, w_step_duty;
    logic [DUTY_W-1:0] r_target, w_target_next, w_new_target;
    logic              r_err;
    logic              w_ready, w_accept;
    logic [DUTY_W:0]   w_sum, w_diff;

    pwm_period_timer #(
        .PERIOD_CYCLES (PERIOD_CYCLES)
    ) u_timer (
        .clock       (clock),
        .reset       (reset),
        .period_tick (period_tick)
    );

    assign tgt.target_ready = w_ready;
    assign duty_out         = r_duty;
    assign err_range        = r_err;
    assign busy             = (r_state == ST_RAMP_UP) || (r_state == ST_RAMP_DN);
    assign at_target        = (r_duty == r_target);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_duty   <= '0;
            r_target <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_duty   <= w_duty_next;
            r_target <= w_target_next;
            r_err    <= w_accept && (tgt.target_duty > C_DUTY_MAX);
        end
    end

    always_comb begin
        w_ready      = (r_state != ST_ESTOP) && !estop;
        w_accept     = tgt.target_valid && w_ready;
        w_new_target = sat_duty(tgt.target_duty, C_DUTY_MAX);
        w_sum        = {1'b0, r_duty} + C_STEP_W;
        w_diff       = {1'b0, r_duty} - {1'b0, r_target};

        // The step always uses the target stored before this edge.
        w_step_duty = r_duty;
        if (period_tick) begin
            if (r_state == ST_RAMP_UP) begin
                w_step_duty = (w_sum > {1'b0, r_target}) ? r_target : w_sum[DUTY_W-1:0];
            end else if (r_state == ST_RAMP_DN) begin
                w_step_duty = ((r_duty > r_target) && (w_diff > C_STEP_W)) ? (r_duty - C_STEP)
                                                                             : r_target;
            end
        end

        w_state_next  = r_state;
        w_duty_next   = w_step_duty;
        w_target_next = r_target;

        if (estop || (r_state == ST_ESTOP)) begin
            w_state_next  = estop ? ST_ESTOP : ST_IDLE;
            w_duty_next   = '0;
            w_target_next = '0;
        end else if (w_accept) begin
            w_target_next = w_new_target;
            if (w_new_target > w_step_duty) begin
                w_state_next = ST_RAMP_UP;
            end else if (w_new_target < w_step_duty) begin
                w_state_next = ST_RAMP_DN;
            end else begin
                w_state_next = ST_IDLE;
            end
        end else if (busy && (r_duty == r_target)) begin
            w_state_next = ST_IDLE;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_pwm_ramp_scheduler.sv
//------------------------------------------------------------------------------
// Module      : tb_pwm_ramp_scheduler
// Description : Directed self-checking bench for the PWM duty ramp scheduler.
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pwm_ramp_scheduler;
    localparam int PERIOD = 25;

    logic       clock;
    logic       reset;
    logic       estop;
    logic [7:0] duty_out;
    logic       period_tick, busy, at_target, err_range;

    int n_tests;
    int n_failed;

    pwm_ramp_scheduler_if u_if ();

    pwm_ramp_scheduler #(
        .PERIOD_CYCLES (PERIOD),
        .DUTY_MAX      (250),
        .STEP          (5)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .tgt         (u_if),
        .estop       (estop),
        .duty_out    (duty_out),
        .period_tick (period_tick),
        .busy        (busy),
        .at_target   (at_target),
        .err_range   (err_range)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Returns at the negedge of the cycle in which period_tick is high.
    task automatic wait_tick_seen(output int cycles);
        cycles = 0;
        for (int i = 1; i <= 2 * PERIOD; i++) begin
            @(negedge clock);
            if (period_tick) begin
                cycles = i;
                break;
            end
        end
        if (cycles == 0) check("tick_timeout", 0, 1);
    endtask

    // Returns one negedge after the tick edge, so the stepped duty is visible.
    task automatic do_tick();
        int c;
        wait_tick_seen(c);
        @(negedge clock);
    endtask

    task automatic send(input logic [7:0] d);
        u_if.target_duty  = d;
        u_if.target_valid = 1'b1;
        @(negedge clock);
        u_if.target_valid = 1'b0;
    endtask

    initial begin
        int c;
        n_tests  = 0;
        n_failed = 0;
        reset    = 1'b0;
        estop    = 1'b0;
        u_if.target_duty  = '0;
        u_if.target_valid = 1'b0;

        repeat (2) @(negedge clock);
        check("rst_duty", duty_out, 0);
        check("rst_at_target", at_target, 1);
        check("rst_busy", busy, 0);
        check("rst_tick", period_tick, 0);
        check("rst_err", err_range, 0);
        check("rst_ready", u_if.target_ready, 1);

        reset = 1'b1;
        wait_tick_seen(c);
        check("first_tick_gap", c, PERIOD - 1);
        wait_tick_seen(c);
        check("tick_period", c, PERIOD);
        check("idle_duty", duty_out, 0);
        @(negedge clock);

        // Ramp 0 -> 20
        send(8'd20);
        check("accept_busy", busy, 1);
        check("accept_no_step", duty_out, 0);
        check("good_no_err", err_range, 0);
        for (int k = 1; k <= 4; k++) begin
            do_tick();
            check("ramp20_step", duty_out, 5 * k);
        end
        repeat (2) @(negedge clock);
        check("ramp20_busy_done", busy, 0);
        check("ramp20_at_target", at_target, 1);

        // Ramp toward 250, reverse at 100
        send(8'd250);
        for (int k = 0; k < 16; k++) do_tick();
        check("mid_ramp_100", duty_out, 100);
        send(8'd90);
        do_tick();
        check("reverse_95", duty_out, 95);
        do_tick();
        check("reverse_90", duty_out, 90);
        repeat (2) @(negedge clock);
        check("reverse_idle", busy, 0);

        // Clamped final step up to 248, then out-of-range request
        send(8'd248);
        for (int k = 0; k < 32; k++) do_tick();
        check("ramp_248", duty_out, 248);
        repeat (2) @(negedge clock);
        send(8'd255);
        check("err_pulse", err_range, 1);
        @(negedge clock);
        check("err_one_cycle", err_range, 0);
        check("sat_busy", busy, 1);
        check("sat_not_at_target", at_target, 0);
        do_tick();
        check("sat_step_250", duty_out, 250);
        repeat (2) @(negedge clock);
        check("sat_at_target", at_target, 1);

        // Accept coinciding with tick: step uses old target
        send(8'd200);
        do_tick();
        check("dn_245", duty_out, 245);
        wait_tick_seen(c);
        u_if.target_duty  = 8'd243;
        u_if.target_valid = 1'b1;
        @(negedge clock);
        u_if.target_valid = 1'b0;
        check("coincide_old_target", duty_out, 240);
        do_tick();
        check("coincide_new_target", duty_out, 243);

        // Emergency stop mid-ramp with a simultaneous command
        send(8'd100);
        for (int k = 0; k < 40 && duty_out > 8'd120; k++) do_tick();
        check("pre_estop_duty", duty_out, 118);
        estop             = 1'b1;
        u_if.target_duty  = 8'd200;
        u_if.target_valid = 1'b1;
        #1;
        check("estop_ready", u_if.target_ready, 0);
        @(negedge clock);
        u_if.target_valid = 1'b0;
        check("estop_duty", duty_out, 0);
        check("estop_busy", busy, 0);
        check("estop_at_target", at_target, 1);
        repeat (3) @(negedge clock);
        check("estop_hold_ready", u_if.target_ready, 0);
        estop = 1'b0;
        #1;
        check("estop_state_ready", u_if.target_ready, 0);
        @(negedge clock);
        check("release_ready", u_if.target_ready, 1);
        check("release_duty", duty_out, 0);
        do_tick();
        check("dropped_cmd", duty_out, 0);

        // Asynchronous reset mid-ramp, mid-period
        send(8'd50);
        do_tick();
        do_tick();
        check("pre_reset_duty", duty_out, 10);
        repeat (3) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_duty", duty_out, 0);
        check("async_busy", busy, 0);
        check("async_at_target", at_target, 1);
        check("async_tick", period_tick, 0);
        @(negedge clock);
        reset = 1'b1;
        wait_tick_seen(c);
        check("reset_tick_gap", c, PERIOD - 1);
        check("post_reset_duty", duty_out, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/pwm_ramp_scheduler.md
Name: pwm_ramp_scheduler

Overview:
Duty-command sequencer that sits in front of the PWM generator and drives its 8-bit duty input (0..250, 250 = constant high).
- Accepts target duty commands over a valid/ready handshake.
- Slews the applied duty toward the target by a fixed step once per PWM period, so loads never see step changes.
- Provides an emergency-stop override and status flags for the software/HW interface.

Parameters:
PERIOD_CYCLES, 2500, clock cycles per PWM period (matches generator period)
DUTY_MAX, 250, largest legal duty code
STEP, 5, duty increment/decrement applied per period tick (1..DUTY_MAX)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
target_duty  in  8  requested duty code
target_valid  in  1  target_duty is valid this cycle
target_ready  out  1  block accepts a target this cycle
estop  in  1  synchronous emergency stop, level-sensitive
duty_out  out  8  applied duty, wired to generator duty input
period_tick  out  1  one-cycle pulse at end of each PWM period
busy  out  1  ramp in progress
at_target  out  1  duty_out equals the stored target
err_range  out  1  one-cycle pulse: accepted target exceeded DUTY_MAX

Behaviour:
- Reset (reset=0, asynchronous): duty_out=0, target reg=0, period counter=0, state=IDLE, period_tick=0, err_range=0.
- Period timer:
  - Counts 0..PERIOD_CYCLES-1 and wraps.
  - period_tick=1 only in the cycle where count==PERIOD_CYCLES-1.
  - Counter runs in all states, including ESTOP.
- Handshake:
  - target_ready = (state!=ESTOP) && !estop (combinational).
  - Transfer occurs on clock edge with target_valid && target_ready.
  - No transfer means target_duty is ignored.
- Range check:
  - An accepted value >DUTY_MAX is stored as DUTY_MAX.
  - err_range pulses high in the cycle after acceptance.
- Retarget: accepted at any time outside ESTOP, including mid-ramp; the new target replaces the old and ramp direction is re-evaluated.
- States:
  - IDLE: duty_out==target.
    - On accept with new target > duty_out -> RAMP_UP.
    - On accept with new target < duty_out -> RAMP_DN.
    - On accept with new target == duty_out -> stay IDLE.
  - RAMP_UP: on period_tick, duty_out <= min(duty_out+STEP, target), using 9-bit intermediate, no overflow.
  - RAMP_DN: on period_tick, duty_out <= (duty_out-target > STEP) ? duty_out-STEP : target, with no underflow.
  - Either ramp state -> IDLE in the cycle after duty_out reaches target.
  - ESTOP: entered from any state when estop=1.
    - duty_out <= 0 and target <= 0 on the next edge, without waiting for a tick.
    - Stays while estop=1; on estop=0 -> IDLE with duty_out=0.
- Timing/latency:
  - duty_out changes only on period_tick edges, except ESTOP forcing.
  - First ramp step occurs at the first period_tick strictly after the accept edge.
  - Accept and period_tick in the same cycle: the step uses the previously stored target; the new target applies from the next tick.
- Simultaneous estop and target_valid: estop wins (ready=0, command dropped).
- Status outputs:
  - busy=1 in RAMP_UP/RAMP_DN.
  - at_target=(duty_out==target reg), registered-consistent, 1 after reset.
- Integration: period_tick is aligned to the generator's rising flag only when both leave reset in the same cycle; this is guaranteed by the top level, not by this block.

Decomposition:
- Shared package pwm_ctrl_pkg: state enum (IDLE, RAMP_UP, RAMP_DN, ESTOP), DUTY_MAX=250, PERIOD_CYCLES=2500, duty width = 8.
- One sub-module: pwm_period_timer (parameterised wrap counter producing period_tick, async active-low reset).
- Ramp FSM and datapath stay in pwm_ramp_scheduler.

Test Plan:
- Reset release, no commands -> duty_out=0, at_target=1, busy=0, period_tick every 2500 cycles exactly.
- Accept 20 from 0, STEP=5 -> duty_out 5,10,15,20 on four consecutive ticks; busy falls the cycle after 20; at_target=1.
- Target 250 from 0, then mid-ramp (duty=100) accept 90 -> direction reverses: 95, 90 on next two ticks, then IDLE.
- Accept 255 -> stored 250, err_range one-cycle pulse; from 248 with STEP=5 next tick yields 250, not 253/overflow.
- estop asserted at duty=120 mid-ramp together with target_valid -> target_ready=0, duty_out=0 next edge, command dropped; release -> IDLE, duty 0, ready=1.
- Async reset asserted mid-period and mid-ramp (no clock edge) -> outputs zero immediately; accept coinciding with tick -> step uses old target.
